// File: rtl/ram8_master_pkg.sv
// rtl/ram8_master_pkg.sv - shared op encodings, state codes and sizing for the ram8 initiator
package ram8_master_pkg;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR       = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_WAIT  = 3'd3;
  localparam state_t ST_RSP      = 3'd4;

  localparam int RAM8_ADDR_W = 3;
  localparam int DEPTH       = 1 << RAM8_ADDR_W;

endpackage

// File: rtl/ram8_lat_timer.sv
// rtl/ram8_lat_timer.sv - read latency down-counter used while waiting for RAM data
module ram8_lat_timer #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_done
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic [1:0] r_cnt;

  // Load the latency on issue, then count down to zero while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= 2'd0;
    end else if (i_load) begin
      r_cnt <= LAT;
    end else if (i_en && (r_cnt != 2'd0)) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_done = (r_cnt == 2'd0);

endmodule

// File: rtl/ram8_master.sv
// rtl/ram8_master.sv - command-driven initiator for the 8x4 RAM; optional write-verify via RAM8_MASTER_VERIFY_EN
module ram8_master
  import ram8_master_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [ADDR_W-1:0] o_rsp_addr,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_last,
  output logic [DATA_W-1:0] o_mem_in,
  output logic [ADDR_W-1:0] o_mem_add,
  output logic              o_mem_load,
  input  logic [DATA_W-1:0] i_mem_out,
  output logic              o_busy,
  output logic              o_vfy_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << ADDR_W) - 1);

  state_t              r_state;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic [ADDR_W-1:0]   r_rsp_addr;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_last;
  logic [DATA_W-1:0]   r_mem_in;
  logic [ADDR_W-1:0]   r_mem_add;
  logic                r_mem_load;
  logic                w_lat_done;
  logic                w_accept;

  assign w_accept = i_cmd_valid && r_cmd_ready;

  ram8_lat_timer #(
    .RD_LAT (RD_LAT)
  ) u_lat_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == ST_RD_ISSUE),
    .i_en   (r_state == ST_RD_WAIT),
    .o_done (w_lat_done)
  );

`ifdef RAM8_MASTER_VERIFY_EN
  logic [DATA_W-1:0] r_wdata;
  logic              r_vfy_err;

  // Remember the written data and flag any read-back mismatch until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdata   <= '0;
      r_vfy_err <= 1'b0;
    end else begin
      if (w_accept && (i_cmd_op == OP_WRITE)) begin
        r_wdata <= i_cmd_wdata;
      end
      if ((r_state == ST_RD_WAIT) && w_lat_done && (r_op == OP_WRITE) &&
          (i_mem_out != r_wdata)) begin
        r_vfy_err <= 1'b1;
      end
    end
  end

  assign o_vfy_err = r_vfy_err;
`else
  assign o_vfy_err = 1'b0;
`endif

  // Main sequencer; RAM pins are registered on state entry and hold between accesses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_WRITE;
      r_addr      <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_mem_in    <= '0;
      r_mem_add   <= '0;
      r_mem_load  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_op <= i_cmd_op;
            case (i_cmd_op)
              OP_WRITE: begin
                r_addr      <= i_cmd_addr;
                r_mem_add   <= i_cmd_addr;
                r_mem_in    <= i_cmd_wdata;
                r_mem_load  <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_state     <= ST_WR;
              end
              OP_READ: begin
                r_addr      <= i_cmd_addr;
                r_mem_add   <= i_cmd_addr;
                r_cmd_ready <= 1'b0;
                r_state     <= ST_RD_ISSUE;
              end
              OP_DUMP: begin
                r_addr      <= '0;
                r_mem_add   <= '0;
                r_cmd_ready <= 1'b0;
                r_state     <= ST_RD_ISSUE;
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
        ST_WR: begin
          r_mem_load <= 1'b0;
`ifdef RAM8_MASTER_VERIFY_EN
          r_state    <= ST_RD_ISSUE;
`else
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
`endif
        end
        ST_RD_ISSUE: begin
          r_state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (w_lat_done) begin
            if (r_op == OP_WRITE) begin
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_rsp_data  <= i_mem_out;
              r_rsp_addr  <= r_addr;
              r_rsp_last  <= (r_op == OP_READ) || (r_addr == LAST_ADDR);
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RSP;
            end
          end
        end
        ST_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if ((r_op == OP_DUMP) && (r_addr != LAST_ADDR)) begin
              r_addr    <= r_addr + 1'b1;
              r_mem_add <= r_addr + 1'b1;
              r_state   <= ST_RD_ISSUE;
            end else begin
              r_cmd_ready <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_last  = r_rsp_last;
  assign o_mem_in    = r_mem_in;
  assign o_mem_add   = r_mem_add;
  assign o_mem_load  = r_mem_load;
  assign o_busy      = (r_state != ST_IDLE);

endmodule
